// File: rtl/eth_tx_arbiter.sv
// Two-sink Avalon-ST arbiter with packet-atomic grants and fair tie-break; one output register (1 cycle transfer-to-out_valid).
// Backpressure: the granted sink sees ready only while the output register is empty or draining; the other sink is held off.
module eth_tx_arbiter #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_valid,
  input  logic               in0_sop,
  input  logic               in0_eop,
  input  logic [EMPTY_W-1:0] in0_empty,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_valid,
  input  logic               in1_sop,
  input  logic               in1_eop,
  input  logic [EMPTY_W-1:0] in1_empty,
  output logic               in1_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  input  logic               out_ready,
  output logic [31:0]        pkt_cnt0,
  output logic [31:0]        pkt_cnt1,
  output logic               proto_err
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state;
  logic   last_grant;
  logic   first_beat;

  logic               out_free;
  logic               xfer0;
  logic               xfer1;
  logic               xfer;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_sop;
  logic               sel_eop;
  logic [EMPTY_W-1:0] sel_empty;

  assign out_free  = !out_valid || out_ready;
  assign in0_ready = (state == GRANT0) && out_free;
  assign in1_ready = (state == GRANT1) && out_free;
  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;
  assign xfer      = xfer0 || xfer1;

  assign sel_data  = (state == GRANT1) ? in1_data  : in0_data;
  assign sel_sop   = (state == GRANT1) ? in1_sop   : in0_sop;
  assign sel_eop   = (state == GRANT1) ? in1_eop   : in0_eop;
  assign sel_empty = (state == GRANT1) ? in1_empty : in0_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      first_beat <= 1'b1;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
      out_empty  <= '0;
      pkt_cnt0   <= 32'd0;
      pkt_cnt1   <= 32'd0;
      proto_err  <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_sop    <= sel_sop;
        out_eop    <= sel_eop;
        out_empty  <= sel_empty;
        first_beat <= sel_eop;
        if (first_beat && !sel_sop) proto_err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (xfer0 && in0_eop) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (xfer1 && in1_eop) pkt_cnt1 <= pkt_cnt1 + 32'd1;

      // Between packets (first_beat set) the grant is re-arbitrated: hand off if the
      // other side waits, fall back to IDLE once the owner has nothing more to send.
      case (state)
        IDLE: begin
          if (in0_valid && (!in1_valid || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
            first_beat <= 1'b1;
          end else if (in1_valid) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
            first_beat <= 1'b1;
          end
        end
        GRANT0: begin
          if (xfer0 && in0_eop) begin
            if (in1_valid) begin
              state      <= GRANT1;
              last_grant <= 1'b1;
            end
          end else if (first_beat && !xfer0) begin
            if (in1_valid) begin
              state      <= GRANT1;
              last_grant <= 1'b1;
            end else if (!in0_valid) begin
              state <= IDLE;
            end
          end
        end
        GRANT1: begin
          if (xfer1 && in1_eop) begin
            if (in0_valid) begin
              state      <= GRANT0;
              last_grant <= 1'b0;
            end
          end else if (first_beat && !xfer1) begin
            if (in0_valid) begin
              state      <= GRANT0;
              last_grant <= 1'b0;
            end else if (!in1_valid) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: directed scenarios plus a randomized packet run checked
// against packet-level expectations (per-port order, atomicity, counts).
module tb_eth_tx_arbiter;
  localparam int DW = 64;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          in0_valid, in0_sop, in0_eop, in0_ready;
  logic          in1_valid, in1_sop, in1_eop, in1_ready;
  logic [EW-1:0] in0_empty, in1_empty, out_empty;
  logic          out_valid, out_sop, out_eop, out_ready;
  logic [31:0]   pkt_cnt0, pkt_cnt1;
  logic          proto_err;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop), .in0_eop(in0_eop),
    .in0_empty(in0_empty), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop), .in1_eop(in1_eop),
    .in1_empty(in1_empty), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .proto_err(proto_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] emp;
  } beat_t;

  beat_t q0[$], q1[$], sent0[$], sent1[$], outq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    vprob   = 100;
  int    rprob   = 100;
  int    cyc     = 0;
  bit    ov_hist[64], sop_hist[64], eop_hist[64];
  bit    saw_r1   = 1'b0;
  bit    saw_both = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int port, input int pkt, input int len, input bit bad_sop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = {port[0], pkt[14:0], i[15:0], $urandom()};
      b.sop = (i == 0) && !bad_sop;
      b.eop = (i == len - 1);
      b.emp = b.eop ? EW'($urandom_range(63)) : '0;
      if (port == 0) begin q0.push_back(b); sent0.push_back(b); end
      else           begin q1.push_back(b); sent1.push_back(b); end
    end
  endtask

  task automatic drive();
    in0_valid = (q0.size() > 0) && (int'($urandom_range(99)) < vprob);
    in1_valid = (q1.size() > 0) && (int'($urandom_range(99)) < vprob);
    if (q0.size() > 0) begin
      in0_data = q0[0].d; in0_sop = q0[0].sop; in0_eop = q0[0].eop; in0_empty = q0[0].emp;
    end
    if (q1.size() > 0) begin
      in1_data = q1[0].d; in1_sop = q1[0].sop; in1_eop = q1[0].eop; in1_empty = q1[0].emp;
    end
  endtask

  // Samples at the falling edge, advances to 1 time unit after the rising edge, then re-drives.
  task automatic tick();
    bit    acc0, acc1;
    beat_t b;
    @(negedge clk);
    acc0 = in0_valid && in0_ready;
    acc1 = in1_valid && in1_ready;
    if (out_valid && out_ready) begin
      b.d = out_data; b.sop = out_sop; b.eop = out_eop; b.emp = out_empty;
      outq.push_back(b);
    end
    if (cyc < 64) begin
      ov_hist[cyc] = out_valid; sop_hist[cyc] = out_sop; eop_hist[cyc] = out_eop;
    end
    if (in1_ready) saw_r1 = 1'b1;
    if (in0_ready && in1_ready) saw_both = 1'b1;
    @(posedge clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    cyc++;
    out_ready = int'($urandom_range(99)) < rprob;
    drive();
  endtask

  task automatic start_log();
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      ov_hist[i] = 1'b0; sop_hist[i] = 1'b0; eop_hist[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rprob = 100; vprob = 100;
    q0.delete(); q1.delete();
    drive();
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop",   out_sop, 0);
    chk("rst_out_eop",   out_eop, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_readys",    {in0_ready, in1_ready}, 0);
    chk("rst_cnts",      {pkt_cnt0, pkt_cnt1}, 0);
    chk("rst_proto_err", proto_err, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    outq.delete(); sent0.delete(); sent1.delete();
    saw_r1 = 1'b0;
  endtask

  task automatic run_until_drained(input int max_cyc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || out_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_timeout", n >= max_cyc, 0);
  endtask

  task automatic cmp_port(input string tag, input int port, input beat_t exp_q[$]);
    int k = 0;
    int bad = 0;
    foreach (outq[i]) begin
      if (outq[i].d[63] == port[0]) begin
        if (k < exp_q.size()) begin
          if (outq[i].d !== exp_q[k].d || outq[i].sop !== exp_q[k].sop ||
              outq[i].eop !== exp_q[k].eop || outq[i].emp !== exp_q[k].emp) bad++;
        end
        k++;
      end
    end
    chk({tag, "_beats"}, k, exp_q.size());
    chk({tag, "_content"}, bad, 0);
  endtask

  function automatic int interleave_errs();
    int   bad = 0;
    bit   in_pkt = 1'b0;
    logic cur = 1'b0;
    foreach (outq[i]) begin
      if (in_pkt && outq[i].d[63] != cur) bad++;
      if (!in_pkt) begin cur = outq[i].d[63]; in_pkt = 1'b1; end
      if (outq[i].eop) in_pkt = 1'b0;
    end
    return bad;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic [DW-1:0] ref_d;
    int bad, first, last, ones;

    rst = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_sop = 1'b0; in0_eop = 1'b0; in0_empty = '0;
    in1_valid = 1'b0; in1_data = '0; in1_sop = 1'b0; in1_eop = 1'b0; in1_empty = '0;
    #3;

    // Single 3-beat packet on sink 0: out_valid on cycles 2..4 after valid rises.
    do_reset();
    push_pkt(0, 0, 3, 1'b0);
    start_log();
    drive();
    repeat (7) tick();
    chk("t31_ov_hist",  {ov_hist[5], ov_hist[4], ov_hist[3], ov_hist[2], ov_hist[1], ov_hist[0]}, 6'b011100);
    chk("t31_sop_hist", {sop_hist[4], sop_hist[3], sop_hist[2]} & {ov_hist[4], ov_hist[3], ov_hist[2]}, 3'b001);
    chk("t31_eop_hist", {eop_hist[4], eop_hist[3], eop_hist[2]} & {ov_hist[4], ov_hist[3], ov_hist[2]}, 3'b100);
    chk("t31_pkt_cnt0", pkt_cnt0, 1);
    chk("t31_in1_ready_seen", saw_r1, 0);
    cmp_port("t31_port0", 0, sent0);

    // Both sinks busy from reset: strict alternation starting with sink 0, no gaps.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, p, 2, 1'b0);
      push_pkt(1, p, 2, 1'b0);
    end
    start_log();
    drive();
    run_until_drained(200);
    bad = 0;
    foreach (outq[i]) if (outq[i].d[63] != 1'(((i / 2) % 2))) bad++;
    chk("t32_order", bad, 0);
    chk("t32_beats", outq.size(), 16);
    first = -1; last = -1; ones = 0;
    for (int i = 0; i < 64; i++) if (ov_hist[i]) begin
      if (first < 0) first = i;
      last = i;
      ones++;
    end
    chk("t32_first_beat_cycle", first, 2);
    chk("t32_no_gap", last - first + 1, ones);
    chk("t32_cnts_equal", {pkt_cnt0, pkt_cnt1}, {32'd4, 32'd4});

    // Output stalled for 5 cycles mid-packet.
    do_reset();
    push_pkt(0, 0, 4, 1'b0);
    drive();
    repeat (3) tick();
    chk("t33_ov_before_stall", out_valid, 1);
    rprob = 0; out_ready = 1'b0;
    ref_d = out_data;
    bad = 0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== ref_d || in0_ready !== 1'b0) bad++;
    end
    chk("t33_stall_hold", bad, 0);
    rprob = 100; out_ready = 1'b1;
    run_until_drained(100);
    cmp_port("t33_port0", 0, sent0);

    // Single-beat packet on sink 1 with empty=20.
    do_reset();
    b.d = 64'h8000_0000_dead_beef; b.sop = 1'b1; b.eop = 1'b1; b.emp = 6'd20;
    q1.push_back(b); sent1.push_back(b);
    drive();
    repeat (6) tick();
    chk("t34_beats", outq.size(), 1);
    cmp_port("t34_port1", 1, sent1);
    chk("t34_pkt_cnt1", pkt_cnt1, 1);
    chk("t34_idle_readys", {in0_ready, in1_ready}, 2'b00);

    // First granted beat without sop sets the sticky error.
    do_reset();
    push_pkt(0, 0, 2, 1'b1);
    drive();
    run_until_drained(100);
    cmp_port("t35_port0", 0, sent0);
    chk("t35_proto_err", proto_err, 1);
    push_pkt(0, 1, 3, 1'b0);
    drive();
    run_until_drained(100);
    chk("t35_proto_err_sticky", proto_err, 1);

    // Reset during beat 2 of a 4-beat packet, then a clean sink-1 packet.
    do_reset();
    push_pkt(0, 0, 4, 1'b0);
    drive();
    repeat (2) tick();
    rst = 1'b1;
    q0.delete();
    drive();
    #1;
    chk("t36_async_ov", out_valid, 0);
    tick();
    chk("t36_next_ov", out_valid, 0);
    chk("t36_cnts", {pkt_cnt0, pkt_cnt1}, 0);
    rst = 1'b0;
    outq.delete(); sent0.delete(); sent1.delete();
    push_pkt(1, 0, 3, 1'b0);
    drive();
    run_until_drained(100);
    cmp_port("t36_port1", 1, sent1);
    chk("t36_no_residual", outq.size(), 3);
    chk("t36_cnt1", pkt_cnt1, 1);

    // Randomized traffic with random valid gaps and backpressure.
    do_reset();
    for (int p = 0; p < 20; p++) begin
      push_pkt(0, p, int'($urandom_range(5, 1)), 1'b0);
      push_pkt(1, p, int'($urandom_range(5, 1)), 1'b0);
    end
    vprob = 70; rprob = 70;
    drive();
    run_until_drained(5000);
    cmp_port("rnd_port0", 0, sent0);
    cmp_port("rnd_port1", 1, sent1);
    chk("rnd_interleave", interleave_errs(), 0);
    chk("rnd_cnt0", pkt_cnt0, 20);
    chk("rnd_cnt1", pkt_cnt1, 20);
    chk("rnd_proto_err", proto_err, 0);
    chk("dual_ready_seen", saw_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 512, beat width in bits of all data ports.
REQ-002 Parameter EMPTY_W, default 6, width of all empty fields.
REQ-003 clk  input  1  single clock; all logic in this domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in0_data/in0_valid/in0_sop/in0_eop/in0_empty  input  DATA_W/1/1/1/EMPTY_W  Avalon-ST sink 0.
REQ-006 in0_ready  output  1  sink 0 ready.
REQ-007 in1_data/in1_valid/in1_sop/in1_eop/in1_empty  input  DATA_W/1/1/1/EMPTY_W  Avalon-ST sink 1.
REQ-008 in1_ready  output  1  sink 1 ready.
REQ-009 out_data/out_valid/out_sop/out_eop/out_empty  output  DATA_W/1/1/1/EMPTY_W  Avalon-ST source to the TX FIFO.
REQ-010 out_ready  input  1  source backpressure.
REQ-011 pkt_cnt0, pkt_cnt1  output  32 each  packets forwarded from sink 0 / sink 1.
REQ-012 proto_err  output  1  sticky: a granted packet's first beat lacked sop.

Function
REQ-013 Transfer on a port SHALL occur in a cycle where valid and ready are both 1; ready is readyLatency 0.
REQ-014 FSM SHALL have states IDLE, GRANT0, GRANT1; one grant at most; inX_ready SHALL be 0 unless state is GRANTX.
REQ-015 In GRANTX, inX_ready SHALL equal (!out_valid || out_ready).
REQ-016 IDLE: if exactly one inX_valid=1, next state GRANTX; if both, grant the port not equal to last_grant; if none, stay IDLE.
REQ-017 last_grant SHALL update to X on every IDLE->GRANTX or GRANTY->GRANTX transition; reset value 1 (port 0 wins the first tie).
REQ-018 Grant SHALL be held packet-atomically until the eop beat of the granted port is transferred; no interleaving of beats from two packets on the output.
REQ-019 On eop transfer in GRANTX: next state GRANT of the other port if its valid=1, else GRANTX if inX_valid=1, else IDLE (no bubble on handoff).
REQ-020 A beat with sop=1 and eop=1 SHALL be a complete packet and release the grant per REQ-019.
REQ-021 Output SHALL be a single register stage: on input transfer, out_* load the input beat and out_valid=1 next cycle; latency 1 cycle from transfer to out_valid.
REQ-022 If out_valid=1 and out_ready=0, all out_* SHALL hold stable; if out_ready=1 and no new transfer, out_valid SHALL go to 0 next cycle.
REQ-023 Full throughput: with out_ready held 1 and a granted source valid, one beat per cycle SHALL pass.
REQ-024 From IDLE with a request, first beat SHALL appear on out_valid 2 cycles after inX_valid rises (1 grant + 1 register).
REQ-025 pkt_cntX SHALL increment by 1 on each eop transfer from sink X; wraps 0xFFFFFFFF -> 0.
REQ-026 proto_err SHALL set when the first beat transferred after a grant transition has sop=0; that beat still forwarded; clears only on rst.
REQ-027 A sop=1 beat in the middle of a granted packet SHALL be forwarded unchanged and not restart arbitration.

Reset
REQ-028 While rst=1: state IDLE, last_grant=1, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, in0_ready=0, in1_ready=0, pkt_cnt0=pkt_cnt1=0, proto_err=0.
REQ-029 Reset asserted mid-packet SHALL abort the packet immediately; after release, the FSM restarts from IDLE with no residual beat on the output.
REQ-030 First grant after rst deasserts SHALL be evaluated no earlier than the first clk edge with rst=0.

Verification
REQ-031 Only in0 sends 3-beat packet, out_ready=1 -> out_valid at cycles 2..4, sop on beat 1, eop on beat 3, pkt_cnt0=1, in1_ready never 1.
REQ-032 Both sinks valid continuously with 2-beat packets from reset -> output order in0,in1,in0,in1, no idle cycle between packets, pkt_cnt0=pkt_cnt1 after each pair.
REQ-033 out_ready=0 for 5 cycles mid-packet -> out_* stable throughout, granted inX_ready=0 after register fills, no beat lost or duplicated.
REQ-034 in1 sends single-beat packet (sop=eop=1, empty=6'd20) while in0 idle -> forwarded with empty=20, state returns to IDLE, pkt_cnt1=1.
REQ-035 in0 granted, first beat sop=0 -> beat forwarded, proto_err=1 and stays 1 until rst.
REQ-036 rst pulse during beat 2 of a 4-beat packet -> out_valid=0 next cycle, counters 0; subsequent new packet from in1 forwarded intact.
